// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds or subtracts two WIDTH-bit operands DIGIT bits per
// clock, least-significant digit first. One DIGIT-bit ripple adder is reused for
// every digit, and the carry between digits is held in a register.
// A result takes N = WIDTH/DIGIT cycles after the start edge. start is only
// sampled in IDLE, so a start while busy is dropped.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, sub        begin an operation; 0 = add, 1 = subtract (latched)
//   a, b, c_in        operands and carry/borrow-in (latched at start)
//   busy, done        busy high in RUN; done pulses for one cycle at completion
//   s, c_out          result and raw final carry (subtract: 1 = no borrow)
//   ovf               signed overflow, only when DIGIT_SERIAL_ADDER_OVF_EN is defined
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
  logic             dig_cout;
  logic             last_dig;

  // Operand registers shift right one digit per cycle, so the adder always
  // takes the low digit and needs no wide input multiplexer.
  assign dig_a = a_q[DIGIT-1:0];
  assign dig_b = b_q[DIGIT-1:0];
  assign {dig_cout, dig_sum} = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
  assign last_dig = (cnt_q == CW'(N - 1));
  assign busy     = (state == RUN);

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  // Carry into the top bit can be recovered from the top sum bit and its inputs.
  logic msb_cin;
  assign msb_cin = dig_sum[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_dig) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s       <= '0;
      c_out   <= 1'b0;
      done    <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start) begin
        // Subtract is a + ~b + ~c_in, so the borrow-in is inverted as well.
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? ~c_in : c_in;
        cnt_q   <= '0;
      end
    end else begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= dig_cout;
      cnt_q   <= cnt_q + 1'b1;
      for (int d = 0; d < N; d++) begin
        if (cnt_q == CW'(d)) s[d*DIGIT +: DIGIT] <= dig_sum;
      end
      done <= last_dig;
      if (last_dig) begin
        c_out <= dig_cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        ovf   <= msb_cin ^ dig_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Testbench for digit_serial_adder: three instances (WIDTH=8 with DIGIT=2, 1, 8)
// share one clock. Stimulus pushes expected results into a queue per instance,
// and a monitor compares them whenever done is seen.
module tb_digit_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       st [3];
  logic       sb [3];
  logic       ci [3];
  logic [7:0] aa [3];
  logic [7:0] bb [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic       co_o [3];
  logic       ov_o [3];
  logic [7:0] s_o [3];

  int   tests;
  int   fails;
  int   nd [3];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb[0]), .a(aa[0]), .b(bb[0]),
    .c_in(ci[0]), .busy(busy_o[0]), .done(done_o[0]), .s(s_o[0]), .c_out(co_o[0])
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , .ovf(ov_o[0])
`endif
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb[1]), .a(aa[1]), .b(bb[1]),
    .c_in(ci[1]), .busy(busy_o[1]), .done(done_o[1]), .s(s_o[1]), .c_out(co_o[1])
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , .ovf(ov_o[1])
`endif
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sb[2]), .a(aa[2]), .b(bb[2]),
    .c_in(ci[2]), .busy(busy_o[2]), .done(done_o[2]), .s(s_o[2]), .c_out(co_o[2])
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    , .ovf(ov_o[2])
`endif
  );

`ifndef DIGIT_SERIAL_ADDER_OVF_EN
  initial for (int k = 0; k < 3; k++) ov_o[k] = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: a - b - c_in is a + ~b + ~c_in; overflow when both addend signs
  // agree and the result sign differs.
  function automatic exp_t model(input logic sub, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin);
    exp_t       m;
    logic [7:0] bx;
    logic       cx;
    logic [8:0] f;
    bx  = sub ? ~b : b;
    cx  = sub ? ~cin : cin;
    f   = {1'b0, a} + {1'b0, bx} + {8'b0, cx};
    m.s = f[7:0];
    m.c = f[8];
    m.o = (a[7] == bx[7]) && (f[7] != a[7]);
    return m;
  endfunction

  task automatic mon_pop(input int k);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      check($sformatf("unexpected_done_%0d", k), 32'd1, 32'd0);
    end else begin
      if (k == 0)      e = q0.pop_front();
      else if (k == 1) e = q1.pop_front();
      else             e = q2.pop_front();
      check($sformatf("s_%0d", k), {24'b0, s_o[k]}, {24'b0, e.s});
      check($sformatf("c_out_%0d", k), {31'b0, co_o[k]}, {31'b0, e.c});
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      check($sformatf("ovf_%0d", k), {31'b0, ov_o[k]}, {31'b0, e.o});
`endif
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (done_o[k] === 1'b1) mon_pop(k);
  end

  task automatic push(input int k, input exp_t e);
    if (k == 0)      q0.push_back(e);
    else if (k == 1) q1.push_back(e);
    else             q2.push_back(e);
  endtask

  // Called at a negedge. Issues one operation, scrambles the inputs after the
  // start edge, optionally pulses start with junk at loop cycle 'glitch', and
  // returns at the negedge where done is seen (so a back-to-back start lands on TN+1).
  task automatic run_op(input int k, input logic sub, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input exp_t e, input int glitch);
    int lat;
    int bcnt;
    bit seen;
    push(k, e);
    st[k] = 1'b1; sb[k] = sub; aa[k] = a; bb[k] = b; ci[k] = cin;
    @(negedge clk);
    st[k] = 1'b0;
    aa[k] = 8'($urandom); bb[k] = 8'($urandom); sb[k] = 1'($urandom); ci[k] = 1'($urandom);
    bcnt = busy_o[k] ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      st[k] = 1'b0;
      if (done_o[k]) seen = 1'b1;
      else if (busy_o[k]) bcnt++;
      if (!seen && lat == glitch) begin
        st[k] = 1'b1;
        aa[k] = 8'($urandom); bb[k] = 8'($urandom); sb[k] = 1'($urandom);
      end
    end
    check($sformatf("latency_%0d", k), seen ? lat : -1, nd[k]);
    check($sformatf("busy_cycles_%0d", k), bcnt, nd[k]);
    check($sformatf("busy_at_done_%0d", k), {31'b0, busy_o[k]}, 32'd0);
  endtask

  function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s; e.c = c; e.o = o;
    return e;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    nd[0] = 4; nd[1] = 8; nd[2] = 1;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; sb[k] = 1'b0; ci[k] = 1'b0; aa[k] = '0; bb[k] = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", {31'b0, busy_o[k]}, 32'd0);
      check("reset_done", {31'b0, done_o[k]}, 32'd0);
      check("reset_s", {24'b0, s_o[k]}, 32'd0);
      check("reset_c_out", {31'b0, co_o[k]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, WIDTH=8 DIGIT=2, expectations worked by hand.
    run_op(0, 1'b0, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0), -1);
    @(negedge clk);
    check("done_clears", {31'b0, done_o[0]}, 32'd0);
    run_op(0, 1'b1, 8'h05, 8'h07, 1'b0, mk(8'hFE, 1'b0, 1'b0), -1);
    @(negedge clk);
    run_op(0, 1'b0, 8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1), -1);
    @(negedge clk);
    run_op(0, 1'b0, 8'h10, 8'h20, 1'b0, mk(8'h30, 1'b0, 1'b0), -1);
    @(negedge clk);
    run_op(0, 1'b1, 8'h00, 8'h00, 1'b1, mk(8'hFF, 1'b0, 1'b0), -1);
    @(negedge clk);
    run_op(0, 1'b1, 8'h80, 8'h01, 1'b0, mk(8'h7F, 1'b1, 1'b1), -1);
    @(negedge clk);
    run_op(0, 1'b0, 8'h01, 8'h00, 1'b1, mk(8'h02, 1'b0, 1'b0), -1);
    @(negedge clk);
    // start pulsed mid-RUN is ignored; next start lands at TN+1 and is itself
    // hit by a start sampled on its final edge TN, which must also be ignored.
    run_op(0, 1'b0, 8'h3C, 8'h0F, 1'b0, mk(8'h4B, 1'b0, 1'b0), 1);
    run_op(0, 1'b0, 8'h12, 8'h34, 1'b0, mk(8'h46, 1'b0, 1'b0), 3);
    repeat (3) @(negedge clk);
    check("s_hold", {24'b0, s_o[0]}, 32'h46);
    check("idle_after_ignored_start", {31'b0, busy_o[0]}, 32'd0);

    // Reset in the middle of an operation discards it.
    st[0] = 1'b1; sb[0] = 1'b0; aa[0] = 8'h55; bb[0] = 8'h22; ci[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy_o[0]}, 32'd0);
    check("midrst_done", {31'b0, done_o[0]}, 32'd0);
    check("midrst_s", {24'b0, s_o[0]}, 32'd0);
    check("midrst_c_out", {31'b0, co_o[0]}, 32'd0);
    check("midrst_ovf", {31'b0, ov_o[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_idle", {31'b0, busy_o[0]}, 32'd0);
    check("post_rst_s", {24'b0, s_o[0]}, 32'd0);
    run_op(0, 1'b0, 8'hA5, 8'h5A, 1'b1, mk(8'h00, 1'b1, 1'b0), -1);
    @(negedge clk);

    // Other digit widths, directed.
    run_op(1, 1'b0, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0), -1);
    run_op(2, 1'b1, 8'h05, 8'h07, 1'b0, mk(8'hFE, 1'b0, 1'b0), -1);
    @(negedge clk);

    // Random operations on each instance, back-to-back.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        logic       rs, rc;
        logic [7:0] ra, rb;
        rs = 1'($urandom); rc = 1'($urandom); ra = 8'($urandom); rb = 8'($urandom);
        run_op(k, rs, ra, rb, rc, model(rs, ra, rb, rc), -1);
      end
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queues_drained", q0.size() + q1.size() + q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Multi-cycle, parametrised successor to the single-bit full adder. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, least-significant digit first, using a chained DIGIT-bit ripple adder and a registered inter-digit carry. It sits in the datapath wherever area matters more than latency, under a start/busy/done handshake with a controller.

## Interface

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT is the digit count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request an operation; sampled only in IDLE.
- sub  in  1  0 = add, 1 = subtract; latched at start.
- a  in  WIDTH  operand A; latched at start.
- b  in  WIDTH  operand B; latched at start.
- c_in  in  1  carry-in (add) or borrow-in (subtract); latched at start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- s  out  WIDTH  result register.
- c_out  out  1  final carry. For subtract it is the raw carry: 1 means no borrow.
- ovf  out  1  signed overflow; present only with DIGIT_SERIAL_ADDER_OVF_EN.

## Operation

- States: IDLE and RUN.
- IDLE → RUN when start=1. The start edge latches:
  - A ← a.
  - B ← (sub ? ~b : b).
  - carry ← (sub ? ~c_in : c_in).
  - Digit counter ← 0.
- Subtract therefore computes a − b − c_in as a + ~b + ~c_in.
- RUN, each edge:
  - Digit d = counter is summed as A[d] + B[d] + carry.
  - The DIGIT-bit sum is written into s[d*DIGIT +: DIGIT].
  - carry ← digit carry-out.
  - counter increments.
- RUN → IDLE on the edge that processes digit N−1. On that edge c_out ← final carry and done ← 1.
- done clears on the next edge unconditionally.
- s and c_out hold their values until the next accepted start. s is partially overwritten digit by digit during RUN and is valid only from the done pulse onward.
- start while busy is ignored. It is neither queued nor able to corrupt the operation.
- Operand changes after the start edge have no effect.
- Reset, at any time including mid-operation:
  - State returns to IDLE; counter and carry clear.
  - busy=0, done=0, s=0, c_out=0, ovf=0.
  - Any in-flight result is discarded.
- Arithmetic is modulo 2^WIDTH, with the carry out of bit WIDTH−1 reported on c_out.

## Timing

- Edge T0 samples start=1 in IDLE. busy=1 from T0 until TN.
- Digits 0..N−1 are processed on edges T1..TN.
- After TN: busy=0, done=1, s/c_out final. Latency from the start edge is N cycles.
- done=0 after TN+1.
- A start sampled at TN+1 is accepted. Back-to-back throughput is one operation per N+1 cycles.
- A start sampled at TN is ignored, because the block is still in RUN.
- DIGIT=WIDTH gives N=1: result after one cycle.
- Critical path: one DIGIT-bit ripple chain plus the carry register.

## Configuration

- DIGIT_SERIAL_ADDER_OVF_EN defined:
  - Adds port ovf.
  - On the final-digit edge, ovf ← carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - ovf holds with s and clears on reset.
- Macro undefined:
  - Port ovf and its logic are absent.
  - All other behaviour is identical.

## Test plan

All scenarios use WIDTH=8, DIGIT=2, so N=4.

- Add with wrap: a=0xFF, b=0x01, c_in=0, sub=0 → done exactly 4 cycles after start, s=0x00, c_out=1, busy high for 4 cycles.
- Subtract with borrow: a=0x05, b=0x07, c_in=0, sub=1 → s=0xFE, c_out=0 (borrow).
- Signed overflow (macro defined): a=0x7F, b=0x01, add → s=0x80, ovf=1, c_out=0. Then a=0x10, b=0x20 → s=0x30, ovf=0.
- start pulsed during RUN with different operands → ignored, first result unaffected. A start at TN+1 (a=0x12, b=0x34) → s=0x46, 4 cycles later.
- rst_n low at T2 of an operation → busy, done, s and c_out all 0 immediately. Nothing happens until a new start; a new start completes correctly.
- Random a, b, c_in, sub over 1000 operations vs reference model, with DIGIT also in {1, 8} → s and c_out match every operation.
